commit_tpu: RTL and testbench
=============================

COMMIT_TPU -- requirements
Module: commit_tpu

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 16: entries in the in-flight table; equals the hazard-table depth and is a power of two, at least 2.
REQ-002 SHALL have parameter WIDTH_NO, default $clog2(NUM_ENTRY): width of the issue/commit number.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 Port clock: input, 1 bit, sole clock, rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-006 Port I_Issue_Req: input, 1 bit, an instruction issued this cycle from the hazard stage.
REQ-007 Port I_Issue_No: input, WIDTH_NO bits, issue number (hazard-stage read pointer) of that instruction.
REQ-008 Port I_Done_S: input, 1 bit, scalar-unit completion.
REQ-009 Port I_Done_S_No: input, WIDTH_NO bits, issue number completed by the scalar unit.
REQ-010 Port I_Done_V: input, 1 bit, vector-unit completion.
REQ-011 Port I_Done_V_No: input, WIDTH_NO bits, issue number completed by the vector unit.
REQ-012 Port O_Commit_Req: output, 1 bit, in-order commit pulse; drives I_Commit_Req of the hazard stage.
REQ-013 Port O_Commit_No: output, WIDTH_NO bits, committed issue number; drives I_Commit_No.
REQ-014 Port O_Full: output, 1 bit, all entries in flight.
REQ-015 Port O_Empty: output, 1 bit, no entry in flight.
REQ-016 Port O_Num: output, WIDTH_NO+1 bits, in-flight count.
REQ-017 Port O_Err: output, 1 bit, sticky protocol-error flag.

Function
REQ-018 SHALL hold per entry a valid bit and a done bit, plus a head pointer, a tail pointer and a count.
REQ-019 Issue accepted when I_Issue_Req=1, not full, and I_Issue_No equals tail: entry valid set, done cleared, tail advances modulo NUM_ENTRY.
REQ-020 Issue while full, or with I_Issue_No not equal to tail: SHALL be dropped and SHALL set O_Err.
REQ-021 Done on either port to a valid entry SHALL set its done bit; both ports naming the same entry in one cycle is legal and idempotent.
REQ-022 Done to an invalid entry SHALL be ignored and SHALL set O_Err, except when it targets the entry being issued in the same cycle, in which case valid and done are both set.
REQ-023 Commit SHALL occur on the edge when the head entry is valid and done: valid and done cleared, head advances, O_Commit_Req=1 and O_Commit_No=old head registered for exactly that cycle.
REQ-024 At most one commit per cycle; commits strictly in issue order; a done entry behind a not-done head SHALL wait.
REQ-025 Latency: done sampled at edge k SHALL produce O_Commit_Req high after edge k+1 (2-cycle), when the entry is head.
REQ-026 Count: +1 on accepted issue, -1 on commit, unchanged when both occur on the same edge; never exceeds NUM_ENTRY or underflows.
REQ-027 O_Full = (O_Num==NUM_ENTRY); O_Empty = (O_Num==0); both combinational from registered count.
REQ-028 Head/tail wrap from NUM_ENTRY-1 to 0 without gap or stall.
REQ-029 An accepted issue SHALL be possible when full only if a commit occurs on the same edge; otherwise REQ-020 applies.

Reset
REQ-030 Reset SHALL immediately clear all valid/done bits, head, tail, count, O_Commit_Req, O_Commit_No and O_Err; O_Empty=1, O_Full=0, O_Num=0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries without emitting a commit.

Configuration
REQ-032 Macro COMMIT_BYPASS_EN defined: done whose number equals head with head valid SHALL commit on the same edge it is sampled (1-cycle latency); not defined: 2-cycle latency per REQ-025.

Verification
REQ-033 Reset, then issue 0,1,2; done 0 -> O_Commit_Req pulse with O_Commit_No=0 two cycles after the done cycle (one with COMMIT_BYPASS_EN); O_Num 3->2.
REQ-034 Issue 0,1; done 1, then done 0 three cycles later -> commits 0 then 1 on consecutive cycles; nothing committed before done 0.
REQ-035 Fill to 16 -> O_Full=1; extra issue dropped, O_Err=1; done 0 plus issue 0 on the same cycle after commit -> O_Num stays 16, tail wraps to 1.
REQ-036 I_Done_S and I_Done_V both naming 3 (head) -> single commit of 3, O_Err=0.
REQ-037 Done to empty entry 5 -> O_Err=1 and stays 1; no commit issued.
REQ-038 Assert reset with 4 in flight -> outputs at reset values immediately; subsequent issue 0 accepted.

Source files
------------

// File: rtl/commit_tpu.sv
// In-order commit table: tracks issued instructions until both in flight and done, then retires them in issue order.
// Optional macro COMMIT_BYPASS_EN: a done naming the valid head entry commits on the same edge it is sampled.
module commit_tpu #(
  parameter int NUM_ENTRY = 16,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                I_Issue_Req,
  input  logic [WIDTH_NO-1:0] I_Issue_No,
  input  logic                I_Done_S,
  input  logic [WIDTH_NO-1:0] I_Done_S_No,
  input  logic                I_Done_V,
  input  logic [WIDTH_NO-1:0] I_Done_V_No,
  output logic                O_Commit_Req,
  output logic [WIDTH_NO-1:0] O_Commit_No,
  output logic                O_Full,
  output logic                O_Empty,
  output logic [WIDTH_NO:0]   O_Num,
  output logic                O_Err
);

  logic [NUM_ENTRY-1:0] valid_reg, valid_next;
  logic [NUM_ENTRY-1:0] done_reg, done_next;
  logic [WIDTH_NO-1:0]  head_reg, tail_reg;
  logic [WIDTH_NO:0]    count_reg;
  logic                 commit_req_reg;
  logic [WIDTH_NO-1:0]  commit_no_reg;
  logic                 err_reg;

  logic full, head_ready, commit, issue_ok;
  logic err_issue, err_s, err_v;

  assign full = (count_reg == (WIDTH_NO+1)'(NUM_ENTRY));

`ifdef COMMIT_BYPASS_EN
  logic head_hit;
  assign head_hit   = (I_Done_S && (I_Done_S_No == head_reg)) ||
                      (I_Done_V && (I_Done_V_No == head_reg));
  assign head_ready = done_reg[head_reg] || head_hit;
`else
  assign head_ready = done_reg[head_reg];
`endif

  assign commit   = valid_reg[head_reg] && head_ready;
  // A full table can still accept an issue when the head retires on the same edge.
  assign issue_ok = I_Issue_Req && (I_Issue_No == tail_reg) && (!full || commit);

  assign err_issue = I_Issue_Req && !issue_ok;
  assign err_s     = I_Done_S && !valid_reg[I_Done_S_No] &&
                     !(issue_ok && (I_Done_S_No == tail_reg));
  assign err_v     = I_Done_V && !valid_reg[I_Done_V_No] &&
                     !(issue_ok && (I_Done_V_No == tail_reg));

  for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_entry
    logic hit, retire, fill;
    assign hit    = (I_Done_S && (I_Done_S_No == WIDTH_NO'(gi))) ||
                    (I_Done_V && (I_Done_V_No == WIDTH_NO'(gi)));
    assign retire = commit && (head_reg == WIDTH_NO'(gi));
    assign fill   = issue_ok && (tail_reg == WIDTH_NO'(gi));
    assign valid_next[gi] = fill || (valid_reg[gi] && !retire);
    // A done aimed at a slot that is retiring belongs to the old occupant, not the new issue.
    assign done_next[gi]  = (valid_reg[gi] && !retire) ? (done_reg[gi] || hit)
                                                       : (fill && hit && !valid_reg[gi]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg      <= '0;
      done_reg       <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      commit_req_reg <= 1'b0;
      commit_no_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      valid_reg      <= valid_next;
      done_reg       <= done_next;
      commit_req_reg <= commit;
      if (commit) begin
        head_reg      <= head_reg + WIDTH_NO'(1);
        commit_no_reg <= head_reg;
      end
      if (issue_ok) begin
        tail_reg <= tail_reg + WIDTH_NO'(1);
      end
      case ({issue_ok, commit})
        2'b10:   count_reg <= count_reg + (WIDTH_NO+1)'(1);
        2'b01:   count_reg <= count_reg - (WIDTH_NO+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (err_issue || err_s || err_v) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign O_Commit_Req = commit_req_reg;
  assign O_Commit_No  = commit_no_reg;
  assign O_Num        = count_reg;
  assign O_Full       = full;
  assign O_Empty      = (count_reg == '0);
  assign O_Err        = err_reg;

endmodule

// File: tb/tb_commit_tpu.sv
// Bench for commit_tpu: queue-based retirement model checked every cycle, plus directed literal scenarios.
module tb_commit_tpu;
  localparam int N  = 16;
  localparam int WN = 4;
`ifdef COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          I_Issue_Req = 1'b0;
  logic [WN-1:0] I_Issue_No = '0;
  logic          I_Done_S = 1'b0;
  logic [WN-1:0] I_Done_S_No = '0;
  logic          I_Done_V = 1'b0;
  logic [WN-1:0] I_Done_V_No = '0;
  logic          O_Commit_Req;
  logic [WN-1:0] O_Commit_No;
  logic          O_Full;
  logic          O_Empty;
  logic [WN:0]   O_Num;
  logic          O_Err;

  commit_tpu #(.NUM_ENTRY(N), .WIDTH_NO(WN)) dut (
    .clock(clock), .reset(reset),
    .I_Issue_Req(I_Issue_Req), .I_Issue_No(I_Issue_No),
    .I_Done_S(I_Done_S), .I_Done_S_No(I_Done_S_No),
    .I_Done_V(I_Done_V), .I_Done_V_No(I_Done_V_No),
    .O_Commit_Req(O_Commit_Req), .O_Commit_No(O_Commit_No),
    .O_Full(O_Full), .O_Empty(O_Empty), .O_Num(O_Num), .O_Err(O_Err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in issue order, each with a done flag.
  typedef struct { int no; bit dn; } ent_t;
  ent_t m_q[$];
  int   m_next = 0;
  bit   m_creq = 0;
  int   m_cno  = 0;
  bit   m_err  = 0;

  function automatic void mark_done(input bit en, input int no, input bit iss, inout bit new_dn);
    bit found = 0;
    if (!en) return;
    foreach (m_q[i]) if (m_q[i].no == no) begin m_q[i].dn = 1; found = 1; end
    if (!found) begin
      if (iss && no == m_next) new_dn = 1;
      else m_err = 1;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q.delete(); m_next = 0; m_creq = 0; m_cno = 0; m_err = 0;
    end else begin
      int sz;
      bit hit_head, commit, iss, new_dn;
      sz = m_q.size();
      hit_head = (sz > 0) && ((I_Done_S && m_q[0].no == int'(I_Done_S_No)) ||
                              (I_Done_V && m_q[0].no == int'(I_Done_V_No)));
      commit = (sz > 0) && (m_q[0].dn || (BYP && hit_head));
      iss = I_Issue_Req && int'(I_Issue_No) == m_next && (sz < N || commit);
      if (I_Issue_Req && !iss) m_err = 1;
      new_dn = 0;
      mark_done(I_Done_S, int'(I_Done_S_No), iss, new_dn);
      mark_done(I_Done_V, int'(I_Done_V_No), iss, new_dn);
      m_creq = commit;
      if (commit) begin m_cno = m_q[0].no; void'(m_q.pop_front()); end
      if (iss) begin m_q.push_back('{m_next, new_dn}); m_next = (m_next + 1) % N; end
    end
  end

  always @(negedge clock) begin
    check("cmp_num",   int'(O_Num), m_q.size());
    check("cmp_full",  int'(O_Full), int'(m_q.size() == N));
    check("cmp_empty", int'(O_Empty), int'(m_q.size() == 0));
    check("cmp_err",   int'(O_Err), int'(m_err));
    check("cmp_creq",  int'(O_Commit_Req), int'(m_creq));
    if (m_creq) check("cmp_cno", int'(O_Commit_No), m_cno);
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic idle(); I_Issue_Req = 0; I_Done_S = 0; I_Done_V = 0; endtask
  task automatic pulse_reset(); idle(); reset = 1; #2; reset = 0; endtask
  task automatic do_issue(input int n); I_Issue_Req = 1; I_Issue_No = WN'(n); tick(); idle(); endtask
  task automatic do_done_s(input int n); I_Done_S = 1; I_Done_S_No = WN'(n); tick(); idle(); endtask

  // Retire head entry n and reissue slot n on the same edge while the table is full.
  task automatic commit_and_issue(input int n);
    I_Done_S = 1; I_Done_S_No = WN'(n);
    if (!BYP) begin tick(); idle(); end
    I_Issue_Req = 1; I_Issue_No = WN'(n);
    tick(); idle();
  endtask

  function automatic int pick_done();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return int'($urandom_range(0, N-1));
    if (r == 1 || m_q.size() == 0) return m_next;
    if (r < 8) return m_q[0].no;
    return m_q[$urandom_range(0, m_q.size()-1)].no;
  endfunction

  initial begin
    int nc;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("rst_num", int'(O_Num), 0);
    check("rst_empty", int'(O_Empty), 1);
    check("rst_full", int'(O_Full), 0);
    check("rst_err", int'(O_Err), 0);
    check("rst_creq", int'(O_Commit_Req), 0);

    // Basic latency: issue 0,1,2 then done 0.
    for (int i = 0; i < 3; i++) do_issue(i);
    check("t33_num3", int'(O_Num), 3);
    do_done_s(0);
    check("t33_req_a", int'(O_Commit_Req), int'(BYP));
    check("t33_num_a", int'(O_Num), BYP ? 2 : 3);
    tick();
    check("t33_req_b", int'(O_Commit_Req), int'(!BYP));
    check("t33_cno", int'(O_Commit_No), 0);
    check("t33_num_b", int'(O_Num), 2);

    // Out-of-order done must wait for the head.
    pulse_reset();
    do_issue(0); do_issue(1);
    I_Done_V = 1; I_Done_V_No = 1; tick(); idle();
    check("t34_wait0", int'(O_Commit_Req), 0);
    for (int i = 0; i < 2; i++) begin tick(); check("t34_wait", int'(O_Commit_Req), 0); end
    do_done_s(0);
    check("t34_req_a", int'(O_Commit_Req), int'(BYP));
    tick();
    check("t34_req_b", int'(O_Commit_Req), 1);
    check("t34_cno_b", int'(O_Commit_No), BYP ? 1 : 0);
    tick();
    check("t34_req_c", int'(O_Commit_Req), int'(!BYP));
    check("t34_cno_c", int'(O_Commit_No), 1);
    check("t34_num", int'(O_Num), 0);

    // Full table, dropped issue, wrap with same-edge commit+issue.
    pulse_reset();
    for (int i = 0; i < N; i++) do_issue(i);
    check("t35_full", int'(O_Full), 1);
    check("t35_num16", int'(O_Num), 16);
    check("t35_err0", int'(O_Err), 0);
    do_issue(0);
    check("t35_drop_num", int'(O_Num), 16);
    check("t35_err1", int'(O_Err), 1);
    commit_and_issue(0);
    check("t35_wrap_num", int'(O_Num), 16);
    check("t35_wrap_req", int'(O_Commit_Req), 1);
    check("t35_wrap_cno", int'(O_Commit_No), 0);
    commit_and_issue(1);
    check("t35_tail1_num", int'(O_Num), 16);
    check("t35_tail1_cno", int'(O_Commit_No), 1);

    // Both units finish the head in the same cycle.
    pulse_reset();
    for (int i = 0; i < 4; i++) do_issue(i);
    for (int i = 0; i < 3; i++) do_done_s(i);
    repeat (3) tick();
    check("t36_num1", int'(O_Num), 1);
    I_Done_S = 1; I_Done_S_No = 3; I_Done_V = 1; I_Done_V_No = 3;
    tick(); idle();
    nc = 0;
    if (O_Commit_Req) nc++;
    for (int i = 0; i < 3; i++) begin tick(); if (O_Commit_Req) nc++; end
    check("t36_ncommit", nc, 1);
    check("t36_cno", int'(O_Commit_No), 3);
    check("t36_err", int'(O_Err), 0);
    check("t36_num0", int'(O_Num), 0);

    // Done to an empty slot.
    pulse_reset();
    do_done_s(5);
    check("t37_err", int'(O_Err), 1);
    nc = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (O_Commit_Req) nc++; end
    check("t37_sticky", int'(O_Err), 1);
    check("t37_ncommit", nc, 0);
    check("t37_num", int'(O_Num), 0);

    // Asynchronous reset with entries in flight.
    pulse_reset();
    for (int i = 0; i < 4; i++) do_issue(i);
    do_issue(7);
    check("t38_pre_num", int'(O_Num), 4);
    check("t38_pre_err", int'(O_Err), 1);
    reset = 1; #1;
    check("t38_num", int'(O_Num), 0);
    check("t38_empty", int'(O_Empty), 1);
    check("t38_full", int'(O_Full), 0);
    check("t38_err", int'(O_Err), 0);
    check("t38_creq", int'(O_Commit_Req), 0);
    check("t38_cno", int'(O_Commit_No), 0);
    #1 reset = 0;
    tick();
    do_issue(0);
    check("t38_post_num", int'(O_Num), 1);
    check("t38_post_err", int'(O_Err), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) pulse_reset();
      I_Issue_Req = ($urandom_range(0, 3) != 0);
      I_Issue_No  = ($urandom_range(0, 24) == 0) ? WN'($urandom_range(0, N-1)) : WN'(m_next);
      I_Done_S    = $urandom_range(0, 1) != 0;
      I_Done_S_No = WN'(pick_done());
      I_Done_V    = $urandom_range(0, 1) != 0;
      I_Done_V_No = WN'(pick_done());
      tick();
    end
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
